// File: rtl/aes_avmm_csr_if.sv
// Avalon-MM slave bus bundle between the HPS bridge and the AES register bank.
// Signal roles:
//   write = !chip_select_n & !write_n. The target samples the enabled byte
//   lanes of write_data on that clock edge.
//   read  = !chip_select_n & !read_n. read_data is combinational from address
//   (zero wait states). It shows the register contents from before any write
//   landing on the same edge.
interface aes_avmm_csr_if;
    logic        chip_select_n;
    logic        write_n;
    logic        read_n;
    logic [5:0]  address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic [31:0] read_data;

    modport master (
        output chip_select_n, write_n, read_n, address, write_data, byte_enable,
        input  read_data
    );

    modport slave (
        input  chip_select_n, write_n, read_n, address, write_data, byte_enable,
        output read_data
    );
endinterface

// File: rtl/aes_avmm_csr.sv
// AES register bank and sequencer: PT/KEY/IV/CT registers, start/done handshake
// with the AES core, CBC chaining, sticky DONE/ERR status and a level interrupt.
module aes_avmm_csr #(
    parameter int KEY_SIZE = 128
) (
    input  logic                clk,
    input  logic                reset,
    aes_avmm_csr_if.slave       bus,
    output logic                irq,
    output logic                core_start,
    output logic [127:0]        core_block,
    output logic [KEY_SIZE-1:0] core_key,
    input  logic                core_done,
    input  logic [127:0]        core_result,
    output logic [1:0]          fsm_state
);
    localparam int KW     = KEY_SIZE / 32;
    localparam int A_PT   = 0;
    localparam int A_KEY  = 4;
    localparam int A_CTRL = 12;
    localparam int A_CT   = 13;
    localparam int A_IV   = 17;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [1:0] KSZ = (KEY_SIZE == 256) ? 2'd2 : (KEY_SIZE == 192) ? 2'd1 : 2'd0;

    logic [1:0]  state;
    logic [31:0] pt  [4];
    logic [31:0] iv  [4];
    logic [31:0] ct  [4];
    logic [31:0] key [KW];
    logic        mode, irq_en, done, err;

    logic                wr, rd, busy, ctrl_wr, start_req, launch, data_sel, err_set, finish;
    logic [127:0]        pt_flat, iv_flat;
    logic [KEY_SIZE-1:0] key_flat;
    logic [31:0]         status, rdata;

    // Overlay the enabled byte lanes of new data onto an existing word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    assign wr        = !bus.chip_select_n && !bus.write_n;
    assign rd        = !bus.chip_select_n && !bus.read_n;
    assign busy      = (state != S_IDLE);
    // All CTRL bits live in byte lane 0, so a CTRL write only counts with lane 0 enabled.
    assign ctrl_wr   = wr && (bus.address == 6'(A_CTRL)) && bus.byte_enable[0];
    assign start_req = ctrl_wr && bus.write_data[0];
    assign launch    = start_req && !busy;
    // PT, KEY and IV form the operation's inputs; these are locked while busy.
    assign data_sel  = (bus.address < 6'(A_CTRL)) ||
                       ((bus.address >= 6'(A_IV)) && (bus.address < 6'(A_IV + 4)));
    assign err_set   = (wr && busy && data_sel) || (start_req && busy);
    // A done pulse is only meaningful while an operation is outstanding.
    assign finish    = (state == S_WAIT) && core_done;

    assign core_start = (state == S_LAUNCH);
    assign irq        = done && irq_en;
    assign fsm_state  = state;
    assign status     = {22'd0, KSZ, 3'd0, err, irq_en, mode, done, busy};

    // Flatten word arrays into the wide vectors seen by the core (word 0 at LSB).
    always_comb begin
        pt_flat  = '0;
        iv_flat  = '0;
        key_flat = '0;
        for (int i = 0; i < 4; i++) begin
            pt_flat[32*i +: 32] = pt[i];
            iv_flat[32*i +: 32] = iv[i];
        end
        for (int i = 0; i < KW; i++) begin
            key_flat[32*i +: 32] = key[i];
        end
    end

    // Zero-latency read mux; unmapped addresses and unimplemented key words read 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.address == 6'(A_PT + i)) rdata = pt[i];
            if (bus.address == 6'(A_CT + i)) rdata = ct[i];
            if (bus.address == 6'(A_IV + i)) rdata = iv[i];
        end
        for (int i = 0; i < KW; i++) begin
            if (bus.address == 6'(A_KEY + i)) rdata = key[i];
        end
        if (bus.address == 6'(A_CTRL)) rdata = status;
        bus.read_data = rd ? rdata : 32'd0;
    end

    // Register bank, status flags, core snapshots and the IDLE/LAUNCH/WAIT sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mode       <= 1'b0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_block <= '0;
            core_key   <= '0;
            for (int i = 0; i < 4; i++) begin
                pt[i] <= '0;
                iv[i] <= '0;
                ct[i] <= '0;
            end
            for (int i = 0; i < KW; i++) begin
                key[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr && !busy && bus.address == 6'(A_PT + i))
                    pt[i] <= merge(pt[i], bus.write_data, bus.byte_enable);
                if (wr && !busy && bus.address == 6'(A_IV + i))
                    iv[i] <= merge(iv[i], bus.write_data, bus.byte_enable);
                else if (finish && mode)
                    iv[i] <= core_result[32*i +: 32];
                if (finish)
                    ct[i] <= core_result[32*i +: 32];
            end
            for (int i = 0; i < KW; i++) begin
                if (wr && !busy && bus.address == 6'(A_KEY + i))
                    key[i] <= merge(key[i], bus.write_data, bus.byte_enable);
            end

            if (ctrl_wr) begin
                mode   <= bus.write_data[2];
                irq_en <= bus.write_data[3];
            end

            // Clears first, then sets, so a completing operation wins over DONE_CLR.
            if (launch || (ctrl_wr && bus.write_data[4])) done <= 1'b0;
            if (finish) done <= 1'b1;

            if (ctrl_wr && bus.write_data[5]) err <= 1'b0;
            if (err_set) err <= 1'b1;

            // Snapshot uses the MODE bit carried by the START write itself.
            if (launch) begin
                core_block <= bus.write_data[2] ? (pt_flat ^ iv_flat) : pt_flat;
                core_key   <= key_flat;
            end

            case (state)
                S_IDLE:   if (launch) state <= S_LAUNCH;
                S_LAUNCH: state <= S_WAIT;
                S_WAIT:   if (core_done) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule
